rgb_maxpool_relu_2x2: RTL and testbench

Streaming post-processing stage directly downstream of the two-layer RGB convolution block. It consumes that block's packed 3-channel signed convolution results in raster order and applies ReLU, 2x2 stride-2 max pooling and a right-shift requantisation with saturation. It emits one pooled 3-channel pixel per 2x2 window, ready to feed the next window-generator/convolution layer at reduced resolution.

---
 rtl/rgb_maxpool_relu_2x2_if.sv | 31 +++
 rtl/rgb_maxpool_relu_2x2.sv | 127 ++++++++++++
 tb/tb_rgb_maxpool_relu_2x2.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_maxpool_relu_2x2_if.sv
// ============================================================================
// Module   : rgb_maxpool_relu_2x2_if
// Brief    : Stream bundle between the RGB conv stage and the 2x2 pooling stage.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface rgb_maxpool_relu_2x2_if #(
  parameter int IN_WIDTH  = 50,
  parameter int OUT_WIDTH = 8
);
  logic [3*IN_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic [3*OUT_WIDTH-1:0] pool_out;
  logic                   pool_valid;
  logic                   sat_flag;
  logic                   frame_done;

  modport master (
    output in_data, in_valid,
    input  pool_out, pool_valid, sat_flag, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output pool_out, pool_valid, sat_flag, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/rgb_maxpool_relu_2x2.sv
// ============================================================================
// Module   : rgb_maxpool_relu_2x2
// Brief    : ReLU + 2x2/2 max pooling + shift requantisation on a 3-channel
//            raster stream, one pooled pixel per window.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rgb_maxpool_relu_2x2 #(
  parameter int IN_WIDTH   = 50,
  parameter int IMAGE_SIZE = 220,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_maxpool_relu_2x2_if.slave bus
);

  localparam int c_cw       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int c_lb_depth = (IMAGE_SIZE / 2 > 0) ? IMAGE_SIZE / 2 : 1;
  localparam int c_lbw      = (c_lb_depth > 1) ? $clog2(c_lb_depth) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(IMAGE_SIZE - 1);

  logic [c_cw-1:0]            col_q, col_d;
  logic [c_cw-1:0]            row_q, row_d;
  logic signed [IN_WIDTH-1:0] pair_q [3];
  logic signed [IN_WIDTH-1:0] pair_d [3];
  logic signed [IN_WIDTH-1:0] line_buf_q [3][c_lb_depth];
  logic [3*OUT_WIDTH-1:0]     pool_out_q, pool_out_d;
  logic                       pool_valid_q, pool_valid_d;
  logic                       sat_flag_q, sat_flag_d;
  logic                       frame_done_q, frame_done_d;

  logic signed [IN_WIDTH-1:0] w_sample [3];
  logic signed [IN_WIDTH-1:0] w_hmax [3];
  logic signed [IN_WIDTH-1:0] w_vmax [3];
  logic [IN_WIDTH-1:0]        w_shifted [3];
  logic [OUT_WIDTH-1:0]       w_out [3];
  logic [2:0]                 w_sat;
  logic                       w_last_col;
  logic                       w_last_row;
  logic                       w_lb_we;
  logic                       w_emit;
  logic [c_lbw-1:0]           w_lb_idx;

  assign w_last_col = (col_q == c_last);
  assign w_last_row = (row_q == c_last);
  assign w_lb_idx   = c_lbw'(col_q >> 1);
  assign w_lb_we    = bus.in_valid & col_q[0] & ~row_q[0];
  assign w_emit     = bus.in_valid & col_q[0] & row_q[0];

  // Per-channel datapath; the trailing column of an odd-sized frame is even, so it never reaches here as an odd col.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_sample[c]  = bus.in_data[(c+1)*IN_WIDTH-1 -: IN_WIDTH];
      w_hmax[c]    = (w_sample[c] > pair_q[c]) ? w_sample[c] : pair_q[c];
      w_vmax[c]    = (w_hmax[c] > line_buf_q[c][w_lb_idx]) ? w_hmax[c] : line_buf_q[c][w_lb_idx];
      w_shifted[c] = w_vmax[c][IN_WIDTH-1] ? '0 : ($unsigned(w_vmax[c]) >> SHIFT);
      w_sat[c]     = |w_shifted[c][IN_WIDTH-1:OUT_WIDTH];
      w_out[c]     = w_sat[c] ? '1 : w_shifted[c][OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = 1'b0;
    sat_flag_d   = 1'b0;
    frame_done_d = 1'b0;
    if (bus.in_valid) begin
      if (w_last_col) begin
        col_d = '0;
        row_d = w_last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        for (int c = 0; c < 3; c++) pair_d[c] = w_sample[c];
      end
      frame_done_d = w_last_col & w_last_row;
    end
    if (w_emit) begin
      pool_valid_d = 1'b1;
      sat_flag_d   = |w_sat;
      pool_out_d   = {w_out[2], w_out[1], w_out[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      for (int c = 0; c < 3; c++) pair_q[c] <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      sat_flag_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      sat_flag_q   <= sat_flag_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Every entry is rewritten on an even row before the following odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_lb_we) begin
      for (int c = 0; c < 3; c++) line_buf_q[c][w_lb_idx] <= w_hmax[c];
    end
  end

  assign bus.pool_out   = pool_out_q;
  assign bus.pool_valid = pool_valid_q;
  assign bus.sat_flag   = sat_flag_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_rgb_maxpool_relu_2x2.sv
// ============================================================================
// Module   : tb_rgb_maxpool_relu_2x2
// Brief    : Scoreboard bench for rgb_maxpool_relu_2x2 (4x4/shift0, 4x4/shift2,
//            5x5/shift0 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rgb_maxpool_relu_2x2;
  localparam int IW = 50;
  localparam int OW = 8;

  typedef struct {
    logic [23:0] pix;
    bit          sat;
    bit          fd;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  exp_t pend_q [3][$];
  exp_t exp_q  [3][$];
  int   fd_q   [3][$];

  logic [3*IW-1:0] drv_data [3];
  logic            drv_valid [3];

  int relu_tab [16] = '{-3, -9, -5, 2, -1, -2, -7, -1, -4, -4, -4, -4, -4, -4, -4, -4};

  rgb_maxpool_relu_2x2_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus [3] ();

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].in_data  = drv_data[g];
    assign bus[g].in_valid = drv_valid[g];

    rgb_maxpool_relu_2x2 #(
      .IN_WIDTH  (IW),
      .IMAGE_SIZE((g == 2) ? 5 : 4),
      .OUT_WIDTH (OW),
      .SHIFT     ((g == 1) ? 2 : 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[g])
    );

    always @(negedge clk) begin : monitor
      exp_t e;
      if (bus[g].pool_valid) begin
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pool_valid dut%0d: got pool_out=%0h expected no output", g, bus[g].pool_out);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("pool_out dut%0d", g), 64'(bus[g].pool_out), 64'(e.pix));
          chk($sformatf("sat_flag dut%0d", g), 64'(bus[g].sat_flag), 64'(e.sat));
          chk($sformatf("frame_done dut%0d", g), 64'(bus[g].frame_done), 64'(e.fd));
          chk($sformatf("latency_cycle dut%0d", g), 64'(cyc), 64'(e.stamp));
        end
      end else if (bus[g].frame_done) begin
        if (fd_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done dut%0d: got 1 expected 0", g);
        end else begin
          chk($sformatf("frame_done_cycle dut%0d", g), 64'(cyc), 64'(fd_q[g].pop_front()));
        end
      end
    end
  end

  function automatic exp_t mk(input int c0, input int c1, input int c2, input bit s, input bit f);
    mk.pix   = {8'(c2), 8'(c1), 8'(c0)};
    mk.sat   = s;
    mk.fd    = f;
    mk.stamp = 0;
  endfunction

  // Hand-computed 4x4 result for ch0=row*4+col, ch1=15-ch0, ch2=7.
  task automatic push_mode0(input int d);
    pend_q[d].push_back(mk(5, 15, 7, 1'b0, 1'b0));
    pend_q[d].push_back(mk(7, 13, 7, 1'b0, 1'b0));
    pend_q[d].push_back(mk(13, 7, 7, 1'b0, 1'b0));
    pend_q[d].push_back(mk(15, 5, 7, 1'b0, 1'b1));
  endtask

  task automatic push_const(input int d, input int v, input bit s);
    for (int i = 0; i < 4; i++) pend_q[d].push_back(mk(v, v, v, s, i == 3));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) drv_valid[d] = 1'b0;
    end
  endtask

  task automatic send_px(input int d, input int v0, input int v1, input int v2,
                         input bit trig, input bit fd_only, input int gap);
    exp_t e;
    while ($urandom_range(0, 99) < gap) begin
      @(posedge clk); #1;
      drv_valid[d] = 1'b0;
    end
    @(posedge clk); #1;
    drv_valid[d] = 1'b1;
    drv_data[d]  = {IW'(v2), IW'(v1), IW'(v0)};
    if (trig && pend_q[d].size() > 0) begin
      e       = pend_q[d].pop_front();
      e.stamp = cyc + 1;
      exp_q[d].push_back(e);
    end
    if (fd_only) fd_q[d].push_back(cyc + 1);
  endtask

  task automatic send_frame(input int d, input int size, input int mode, input int val,
                            input int gap, input int npix);
    int r, c, v0, v1, v2;
    for (int p = 0; p < npix; p++) begin
      r = p / size;
      c = p % size;
      case (mode)
        0:       begin v0 = r * size + c; v1 = 15 - v0; v2 = 7;   end
        1:       begin v0 = val;          v1 = val;     v2 = val; end
        default: begin v0 = relu_tab[p];  v1 = -v0;     v2 = 0;   end
      endcase
      send_px(d, v0, v1, v2, (r % 2 == 1) && (c % 2 == 1),
              (size % 2 == 1) && (p == size * size - 1), gap);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      drv_valid[d] = 1'b0;
      drv_data[d]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pool_out", 64'(bus[0].pool_out), 64'd0);
    chk("reset pool_valid", 64'(bus[0].pool_valid), 64'd0);
    chk("reset sat_flag", 64'(bus[1].sat_flag), 64'd0);
    chk("reset frame_done", 64'(bus[2].frame_done), 64'd0);
    rst = 1'b0;
    idle(2);

    // Pooling order, continuous stream
    push_mode0(0);
    send_frame(0, 4, 0, 0, 0, 16);
    idle(2);

    // ReLU and signed max
    pend_q[0].push_back(mk(0, 9, 0, 1'b0, 1'b0));
    pend_q[0].push_back(mk(2, 7, 0, 1'b0, 1'b0));
    pend_q[0].push_back(mk(0, 4, 0, 1'b0, 1'b0));
    pend_q[0].push_back(mk(0, 4, 0, 1'b0, 1'b1));
    send_frame(0, 4, 2, 0, 0, 16);
    idle(2);

    // Saturation at SHIFT=0
    push_const(0, 255, 1'b1);
    send_frame(0, 4, 1, 300, 0, 16);
    idle(2);

    // Random gaps
    push_mode0(0);
    send_frame(0, 4, 0, 0, 40, 16);
    idle(2);

    // Partial frame aborted by reset
    pend_q[0].push_back(mk(5, 15, 7, 1'b0, 1'b0));
    send_frame(0, 4, 0, 0, 0, 6);
    idle(2);
    rst = 1'b1;
    #1;
    chk("midreset pool_out", 64'(bus[0].pool_out), 64'd0);
    chk("midreset pool_valid", 64'(bus[0].pool_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    push_mode0(0);
    send_frame(0, 4, 0, 0, 0, 16);

    // Back-to-back frames
    push_mode0(0);
    push_mode0(0);
    send_frame(0, 4, 0, 0, 0, 16);
    send_frame(0, 4, 0, 0, 0, 16);
    idle(3);

    // SHIFT=2 instance
    push_const(1, 75, 1'b0);
    send_frame(1, 4, 1, 300, 0, 16);
    idle(2);
    push_const(1, 255, 1'b0);
    send_frame(1, 4, 1, 1023, 0, 16);
    idle(2);

    // Odd size: trailing row and column dropped
    pend_q[2].push_back(mk(6, 15, 7, 1'b0, 1'b0));
    pend_q[2].push_back(mk(8, 13, 7, 1'b0, 1'b0));
    pend_q[2].push_back(mk(16, 5, 7, 1'b0, 1'b0));
    pend_q[2].push_back(mk(18, 3, 7, 1'b0, 1'b0));
    send_frame(2, 5, 0, 0, 0, 25);
    idle(4);

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("pending_outputs dut%0d", d), 64'(pend_q[d].size() + exp_q[d].size()), 64'd0);
      chk($sformatf("pending_frame_done dut%0d", d), 64'(fd_q[d].size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
